// File: rtl/mmu_walk_arbiter.sv
// ============================================================================
// Module      : mmu_walk_arbiter
// Description : Arbitrates fetch and data translation requests onto a single
//               SV32 table-walker port and sequences TLB flushes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_walk_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_address,
    output logic [31:0] if_pte,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_address,
    output logic [31:0] d_pte,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        walk_valid,
    input  logic        walk_ready,
    output logic [31:0] walk_address,
    output logic        walk_is_instruction,
    input  logic [31:0] walk_pte,
    output logic        walk_tlb_flush,
    output logic [31:0] walk_count_if,
    output logic [31:0] walk_count_d
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_RESP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_if_q, gnt_if_d;
    logic        last_d_q, last_d_d;
    logic        keep_q, keep_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] if_pte_q, if_pte_d;
    logic [31:0] d_pte_q, d_pte_d;
    logic [31:0] cnt_if_q, cnt_if_d;
    logic [31:0] cnt_d_q, cnt_d_d;
    logic        flush_pend_q, flush_pend_d;
    logic        flush_prev_q;
    logic        flush_done_q;
    logic        block_if_q;
    logic        block_d_q;

    logic        w_flush_rise;
    logic        w_flush_pend;
    logic        w_req_if;
    logic        w_req_d;
    logic        w_pick_if;
    logic        w_gnt_valid;
    logic        w_keep_live;

    // A requester that was just answered still shows valid for one cycle;
    // masking it keeps it from being granted a second, spurious walk.
    assign w_flush_rise = flush_req & ~flush_prev_q;
    assign w_flush_pend = flush_pend_q | w_flush_rise;
    assign w_req_if     = if_valid & ~block_if_q;
    assign w_req_d      = d_valid & ~block_d_q;
    assign w_pick_if    = w_req_if & (~w_req_d | ((ROUND_ROBIN != 0) & last_d_q));
    assign w_gnt_valid  = gnt_if_q ? if_valid : d_valid;
    assign w_keep_live  = keep_q & w_gnt_valid;

    always_comb begin
        state_d      = state_q;
        gnt_if_d     = gnt_if_q;
        last_d_d     = last_d_q;
        keep_d       = keep_q;
        addr_d       = addr_q;
        if_pte_d     = if_pte_q;
        d_pte_d      = d_pte_q;
        cnt_if_d     = cnt_if_q;
        cnt_d_d      = cnt_d_q;
        flush_pend_d = w_flush_pend;
        case (state_q)
            ST_IDLE: begin
                if (w_flush_pend) begin
                    state_d      = ST_FLUSH;
                    flush_pend_d = 1'b0;
                end else if (w_req_if || w_req_d) begin
                    state_d  = ST_WALK;
                    gnt_if_d = w_pick_if;
                    addr_d   = w_pick_if ? if_address : d_address;
                    keep_d   = 1'b1;
                end
            end
            ST_WALK: begin
                // Once the requester lets go, the walk still drains but its result is dropped.
                keep_d = w_keep_live;
                if (walk_ready) begin
                    state_d = ST_RESP;
                    if (w_keep_live) begin
                        if (gnt_if_q) begin
                            if_pte_d = walk_pte;
                            cnt_if_d = cnt_if_q + 32'd1;
                        end else begin
                            d_pte_d = walk_pte;
                            cnt_d_d = cnt_d_q + 32'd1;
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                last_d_d = ~gnt_if_q;
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_if_q     <= 1'b0;
            last_d_q     <= 1'b1;
            keep_q       <= 1'b0;
            addr_q       <= 32'd0;
            if_pte_q     <= 32'd0;
            d_pte_q      <= 32'd0;
            cnt_if_q     <= 32'd0;
            cnt_d_q      <= 32'd0;
            flush_pend_q <= 1'b0;
            flush_prev_q <= 1'b0;
            flush_done_q <= 1'b0;
            block_if_q   <= 1'b0;
            block_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_if_q     <= gnt_if_d;
            last_d_q     <= last_d_d;
            keep_q       <= keep_d;
            addr_q       <= addr_d;
            if_pte_q     <= if_pte_d;
            d_pte_q      <= d_pte_d;
            cnt_if_q     <= cnt_if_d;
            cnt_d_q      <= cnt_d_d;
            flush_pend_q <= flush_pend_d;
            flush_prev_q <= flush_req;
            flush_done_q <= (state_q == ST_FLUSH);
            block_if_q   <= if_ready;
            block_d_q    <= d_ready;
        end
    end

    assign walk_valid          = (state_q == ST_WALK);
    assign walk_tlb_flush      = (state_q == ST_FLUSH);
    assign walk_address        = addr_q;
    assign walk_is_instruction = walk_valid & gnt_if_q;
    assign if_ready            = (state_q == ST_RESP) & keep_q & gnt_if_q;
    assign d_ready             = (state_q == ST_RESP) & keep_q & ~gnt_if_q;
    assign if_pte              = if_pte_q;
    assign d_pte               = d_pte_q;
    assign walk_count_if       = cnt_if_q;
    assign walk_count_d        = cnt_d_q;
    assign flush_done          = flush_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mmu_walk_arbiter.sv
// ============================================================================
// Module      : tb_mmu_walk_arbiter
// Description : Self-checking bench for mmu_walk_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmu_walk_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, d_valid, if_valid0, d_valid0;
    logic [31:0] if_address, d_address;
    logic        flush_req, walk_ready, walk_ready0;
    logic [31:0] walk_pte;

    logic        if_ready, d_ready, flush_done, walk_valid, walk_is_instruction, walk_tlb_flush;
    logic [31:0] if_pte, d_pte, walk_address, walk_count_if, walk_count_d;
    logic        if_ready0, d_ready0, flush_done0, walk_valid0, walk_is_instruction0, walk_tlb_flush0;
    logic [31:0] if_pte0, d_pte0, walk_address0, walk_count_if0, walk_count_d0;

    int checks = 0;
    int errors = 0;

    // Reference model: what a correct arbiter has delivered so far.
    bit          m_last_d;
    logic [31:0] m_cnt_if, m_cnt_d, m_pte_if, m_pte_d;

    mmu_walk_arbiter #(.ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_address(if_address), .if_pte(if_pte),
        .d_valid(d_valid), .d_ready(d_ready), .d_address(d_address), .d_pte(d_pte),
        .flush_req(flush_req), .flush_done(flush_done),
        .walk_valid(walk_valid), .walk_ready(walk_ready), .walk_address(walk_address),
        .walk_is_instruction(walk_is_instruction), .walk_pte(walk_pte),
        .walk_tlb_flush(walk_tlb_flush),
        .walk_count_if(walk_count_if), .walk_count_d(walk_count_d)
    );

    mmu_walk_arbiter #(.ROUND_ROBIN(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_valid(if_valid0), .if_ready(if_ready0), .if_address(if_address), .if_pte(if_pte0),
        .d_valid(d_valid0), .d_ready(d_ready0), .d_address(d_address), .d_pte(d_pte0),
        .flush_req(flush_req), .flush_done(flush_done0),
        .walk_valid(walk_valid0), .walk_ready(walk_ready0), .walk_address(walk_address0),
        .walk_is_instruction(walk_is_instruction0), .walk_pte(walk_pte),
        .walk_tlb_flush(walk_tlb_flush0),
        .walk_count_if(walk_count_if0), .walk_count_d(walk_count_d0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1;
        if_valid = 0; d_valid = 0; if_valid0 = 0; d_valid0 = 0;
        flush_req = 0; walk_ready = 0; walk_ready0 = 0; walk_pte = 32'd0;
        if_address = 32'd0; d_address = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last_d = 1'b1; m_cnt_if = 0; m_cnt_d = 0; m_pte_if = 0; m_pte_d = 0;
    endtask

    // Act as the walker for one granted walk and check it end to end.
    task automatic serve(input bit is_if, input logic [31:0] addr, input int lat,
                         input logic [31:0] pte, input bit chg, input bit fl);
        int n;
        n = 0;
        while (walk_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL walk_start: walk_valid=%b never rose, required 1", walk_valid);
            return;
        end
        for (int k = 0; k <= lat; k++) begin
            checks++;
            if (walk_address !== addr || walk_is_instruction !== is_if || walk_tlb_flush !== 1'b0
                || if_ready !== 1'b0 || d_ready !== 1'b0) begin
                errors++;
                $display("FAIL walk_cycle: addr=%h instr=%b flush=%b rdy=%b%b, required addr=%h instr=%b flush=0 rdy=00",
                         walk_address, walk_is_instruction, walk_tlb_flush, if_ready, d_ready, addr, is_if);
            end
            if (chg && k == 0) begin
                if (is_if) if_address = 32'h0000_2000;
                else       d_address  = 32'h0000_2000;
            end
            flush_req = (fl && k == 0);
            if (k == lat) begin
                walk_ready = 1'b1;
                walk_pte   = pte;
            end
            @(negedge clk);
        end
        walk_ready = 1'b0;
        flush_req  = 1'b0;
        walk_pte   = $urandom;
        if (is_if) begin m_pte_if = pte; m_cnt_if++; end
        else begin m_pte_d = pte; m_cnt_d++; end
        m_last_d = !is_if;
        checks++;
        if (walk_valid !== 1'b0 || if_ready !== is_if || d_ready !== !is_if || if_pte !== m_pte_if
            || d_pte !== m_pte_d || walk_count_if !== m_cnt_if || walk_count_d !== m_cnt_d) begin
            errors++;
            $display("FAIL resp: wv=%b rdy=%b%b pte=%h/%h cnt=%0d/%0d, required wv=0 rdy=%b%b pte=%h/%h cnt=%0d/%0d",
                     walk_valid, if_ready, d_ready, if_pte, d_pte, walk_count_if, walk_count_d,
                     is_if, !is_if, m_pte_if, m_pte_d, m_cnt_if, m_cnt_d);
        end
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL resp_single: rdy=%b%b one cycle after response, required 00", if_ready, d_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_valid = 0; d_valid = 0; if_valid0 = 0; d_valid0 = 0;
        flush_req = 0; walk_ready = 0; walk_ready0 = 0; walk_pte = 32'd0;
        if_address = 32'd0; d_address = 32'd0;
        @(negedge clk);
        checks++;
        if ({if_ready, d_ready, if_pte, d_pte, flush_done, walk_valid, walk_address, walk_is_instruction,
             walk_tlb_flush, walk_count_if, walk_count_d} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: a DUT output is nonzero under reset (wv=%b cnt=%0d/%0d), required all 0",
                     walk_valid, walk_count_if, walk_count_d);
        end
        checks++;
        if ({if_ready0, d_ready0, if_pte0, d_pte0, flush_done0, walk_valid0, walk_address0,
             walk_is_instruction0, walk_tlb_flush0, walk_count_if0, walk_count_d0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_rr0: a fixed-priority DUT output is nonzero under reset, required all 0");
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (walk_valid !== 1'b0 || walk_tlb_flush !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: wv=%b flush=%b done=%b after release, required 0 0 0",
                     walk_valid, walk_tlb_flush, flush_done);
        end
    endtask

    task automatic test_basic();
        if_valid = 1'b1; if_address = 32'h8000_1234;
        serve(1'b1, 32'h8000_1234, 3, 32'h2000_00CF, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (walk_valid !== 1'b0 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL no_regrant: wv=%b if_ready=%b while answered fetch still valid, required 0 0",
                     walk_valid, if_ready);
        end
        if_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie_rr();
        bit first_if;
        apply_reset();
        if_address = 32'hA000_0000; d_address = 32'hB000_0000;
        if_valid = 1'b1; d_valid = 1'b1;
        first_if = m_last_d;
        serve(first_if, first_if ? 32'hA000_0000 : 32'hB000_0000, 1, 32'h1111_0001, 1'b0, 1'b0);
        if (first_if) if_valid = 1'b0; else d_valid = 1'b0;
        serve(!first_if, first_if ? 32'hB000_0000 : 32'hA000_0000, 0, 32'h2222_0002, 1'b0, 1'b0);
        if_valid = 1'b0; d_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        int n;
        apply_reset();
        if_address = 32'hC000_0010; d_address = 32'hD000_0020;
        if_valid0 = 1'b1; d_valid0 = 1'b1;
        for (int w = 0; w < 2; w++) begin
            n = 0;
            while (walk_valid0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (walk_valid0 !== 1'b1 || walk_is_instruction0 !== (w == 1)
                || walk_address0 !== ((w == 1) ? 32'hC000_0010 : 32'hD000_0020)) begin
                errors++;
                $display("FAIL fixed_grant%0d: wv=%b instr=%b addr=%h, required wv=1 instr=%0d", w,
                         walk_valid0, walk_is_instruction0, walk_address0, (w == 1));
            end
            walk_ready0 = 1'b1; walk_pte = 32'h5A5A_0000 + w;
            @(negedge clk);
            walk_ready0 = 1'b0;
            checks++;
            if (if_ready0 !== (w == 1) || d_ready0 !== (w == 0)
                || (w == 0 && (d_pte0 !== 32'h5A5A_0000 || walk_count_d0 !== 32'd1))
                || (w == 1 && (if_pte0 !== 32'h5A5A_0001 || walk_count_if0 !== 32'd1))) begin
                errors++;
                $display("FAIL fixed_resp%0d: rdy=%b%b pte=%h/%h cnt=%0d/%0d", w,
                         if_ready0, d_ready0, if_pte0, d_pte0, walk_count_if0, walk_count_d0);
            end
            if (w == 0) d_valid0 = 1'b0; else if_valid0 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_addr_stable();
        d_valid = 1'b1; d_address = 32'h0000_1000;
        serve(1'b0, 32'h0000_1000, 3, 32'h0BAD_F00D, 1'b1, 1'b0);
        d_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop();
        int n;
        d_valid = 1'b1; d_address = 32'h0000_3000;
        n = 0;
        while (walk_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        d_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        walk_ready = 1'b1; walk_pte = 32'hDEAD_BEEF;
        @(negedge clk);
        walk_ready = 1'b0;
        m_last_d = 1'b1;
        checks++;
        if (d_ready !== 1'b0 || if_ready !== 1'b0 || d_pte !== m_pte_d || walk_count_d !== m_cnt_d) begin
            errors++;
            $display("FAIL drop_discard: rdy=%b%b d_pte=%h cnt=%0d, required rdy=00 d_pte=%h cnt=%0d",
                     if_ready, d_ready, d_pte, walk_count_d, m_pte_d, m_cnt_d);
        end
        @(negedge clk);
        checks++;
        if (walk_valid !== 1'b0 || walk_tlb_flush !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: wv=%b flush=%b d_ready=%b, required 0 0 0", walk_valid, walk_tlb_flush, d_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_flush_during_walk();
        d_valid = 1'b1; d_address = 32'h0040_0000;
        serve(1'b0, 32'h0040_0000, 2, 32'h7777_0707, 1'b0, 1'b1);
        d_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (walk_tlb_flush !== 1'b1 || walk_valid !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: flush=%b wv=%b done=%b, required 1 0 0", walk_tlb_flush, walk_valid, flush_done);
        end
        @(negedge clk);
        checks++;
        if (walk_tlb_flush !== 1'b0 || flush_done !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: flush=%b done=%b, required 0 1", walk_tlb_flush, flush_done);
        end
        @(negedge clk);
        checks++;
        if (flush_done !== 1'b0 || walk_tlb_flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_once: flush=%b done=%b, required 0 0", walk_tlb_flush, flush_done);
        end
    endtask

    task automatic test_flush_held();
        int nt, nd;
        for (int r = 0; r < 2; r++) begin
            nt = 0; nd = 0;
            flush_req = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (walk_tlb_flush === 1'b1) nt++;
                if (flush_done === 1'b1) nd++;
                if (walk_tlb_flush === 1'b1 && walk_valid === 1'b1) nt += 100;
            end
            flush_req = 1'b0;
            @(negedge clk);
            checks++;
            if (nt != 1 || nd != 1) begin
                errors++;
                $display("FAIL flush_held%0d: flush cycles=%0d done pulses=%0d, required 1 1", r, nt, nd);
            end
        end
    endtask

    task automatic test_random();
        int sel, lat;
        bit first_if;
        logic [31:0] a_if, a_d;
        for (int it = 0; it < 24; it++) begin
            sel = $urandom_range(1, 3);
            a_if = $urandom; a_d = $urandom;
            if_address = a_if; d_address = a_d;
            if_valid = (sel != 2); d_valid = (sel != 1);
            first_if = (sel == 1) || (sel == 3 && m_last_d);
            lat = $urandom_range(0, 3);
            serve(first_if, first_if ? a_if : a_d, lat, $urandom, 1'b0, 1'b0);
            if (first_if) if_valid = 1'b0; else d_valid = 1'b0;
            if (sel == 3) begin
                lat = $urandom_range(0, 3);
                serve(!first_if, first_if ? a_d : a_if, lat, $urandom, 1'b0, 1'b0);
                if_valid = 1'b0; d_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_walk();
        int n;
        if_valid = 1'b1; if_address = 32'h1234_5678;
        n = 0;
        while (walk_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (walk_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: walk_valid=%b right after reset assertion, required 0", walk_valid);
        end
        @(negedge clk);
        checks++;
        if ({if_ready, d_ready, if_pte, d_pte, flush_done, walk_valid, walk_address, walk_is_instruction,
             walk_tlb_flush, walk_count_if, walk_count_d} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: cnt=%0d/%0d pte=%h/%h, required all outputs 0",
                     walk_count_if, walk_count_d, if_pte, d_pte);
        end
        if_valid = 1'b0;
        rst = 1'b0;
        m_last_d = 1'b1; m_cnt_if = 0; m_cnt_d = 0; m_pte_if = 0; m_pte_d = 0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (if_ready !== 1'b0 || d_ready !== 1'b0 || flush_done !== 1'b0 || walk_valid !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_quiet: %0d cycles with activity after reset release, required 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_rr();
        test_fixed_priority();
        test_addr_stable();
        test_drop();
        test_flush_during_walk();
        test_flush_held();
        test_random();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
